// File: rtl/byte_fifo_ctrl.sv
// byte_fifo_ctrl
//   Single-clock byte FIFO controller for an external 2K x 9 dual-port block
//   RAM. Port A writes and port B reads. The RAM output latch is the head
//   register, so both sides present a first-word-fall-through valid/ready
//   handshake. A parity bit is generated on write and checked on the head.
//
// Ports
//   CLK, RST          clock (rising edge), asynchronous active-high reset
//   FLUSH             one-cycle synchronous clear of pointers, head and error
//   WR_VALID/READY    producer handshake, WR_DATA is the byte offered
//   RD_VALID/READY    consumer handshake, RD_DATA is the head byte
//   RD_PERR           parity mismatch on the head (only with RD_VALID)
//   PERR_STICKY       latched parity error, cleared by RST or FLUSH
//   COUNT             entries held, RAM contents plus the head
//   RAM_*             address/data/enable signals to the dual-port RAM
module byte_fifo_ctrl #(
    parameter int unsigned ADDR_W     = 9,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            FLUSH,
    input  logic            WR_VALID,
    output logic            WR_READY,
    input  logic [7:0]      WR_DATA,
    output logic            RD_VALID,
    input  logic            RD_READY,
    output logic [7:0]      RD_DATA,
    output logic            RD_PERR,
    output logic            PERR_STICKY,
    output logic [ADDR_W:0] COUNT,
    output logic [10:0]     RAM_ADDRA,
    output logic [7:0]      RAM_DIA,
    output logic            RAM_DIPA,
    output logic            RAM_ENA,
    output logic            RAM_WEA,
    output logic [10:0]     RAM_ADDRB,
    output logic            RAM_ENB,
    input  logic [7:0]      RAM_DOB,
    input  logic            RAM_DOPB
);

    localparam int unsigned PTR_W = ADDR_W + 1;

    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic            rd_valid_q, rd_valid_d;
    logic            perr_sticky_q, perr_sticky_d;

    logic [ADDR_W:0] ram_cnt;
    logic            wr_accept;
    logic            fetch;
    logic            head_perr;

    // Pointers carry one extra wrap bit, so the difference is the exact
    // number of entries still in the RAM (0..DEPTH).
    assign ram_cnt = wr_ptr_q - rd_ptr_q;

    // ram_cnt never exceeds DEPTH, so its MSB is set only when exactly full.
    assign WR_READY  = !RST && !FLUSH && !ram_cnt[ADDR_W];
    assign wr_accept = WR_VALID && WR_READY;

    // Refill the head when it is empty or being consumed this cycle. Only
    // entries committed at earlier edges count, so a fetch never hits the
    // address being written in the same cycle.
    assign fetch = !FLUSH && (ram_cnt != '0) && (!rd_valid_q || RD_READY);

    assign head_perr = rd_valid_q && ((^RAM_DOB) ^ RAM_DOPB ^ PARITY_ODD);

    assign RD_VALID    = rd_valid_q;
    assign RD_DATA     = RAM_DOB;
    assign RD_PERR     = head_perr;
    assign PERR_STICKY = perr_sticky_q;
    assign COUNT       = ram_cnt + PTR_W'(rd_valid_q);

    assign RAM_ENA  = wr_accept;
    assign RAM_WEA  = wr_accept;
    assign RAM_ENB  = fetch;
    assign RAM_DIA  = RST ? 8'h00 : WR_DATA;
    assign RAM_DIPA = RST ? 1'b0 : ((^WR_DATA) ^ PARITY_ODD);

    always_comb begin
        RAM_ADDRA = '0;
        RAM_ADDRB = '0;
        RAM_ADDRA[ADDR_W-1:0] = wr_ptr_q[ADDR_W-1:0];
        RAM_ADDRB[ADDR_W-1:0] = rd_ptr_q[ADDR_W-1:0];
    end

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        rd_valid_d    = rd_valid_q;
        perr_sticky_d = perr_sticky_q;
        if (FLUSH) begin
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            rd_valid_d    = 1'b0;
            perr_sticky_d = 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (fetch) begin
                rd_ptr_d   = rd_ptr_q + PTR_W'(1);
                rd_valid_d = 1'b1;
            end else if (RD_READY) begin
                rd_valid_d = 1'b0;
            end
            if (head_perr) begin
                perr_sticky_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            rd_valid_q    <= 1'b0;
            perr_sticky_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            rd_valid_q    <= rd_valid_d;
            perr_sticky_q <= perr_sticky_d;
        end
    end

endmodule

// File: tb/tb_byte_fifo_ctrl.sv
module tb_byte_fifo_ctrl;

    localparam int unsigned AW  = 4;
    localparam int          DEP = 16;

    logic          CLK = 1'b0;
    logic          RST;
    logic          FLUSH;
    logic          WR_VALID;
    logic          WR_READY;
    logic [7:0]    WR_DATA;
    logic          RD_VALID;
    logic          RD_READY;
    logic [7:0]    RD_DATA;
    logic          RD_PERR;
    logic          PERR_STICKY;
    logic [AW:0]   COUNT;
    logic [10:0]   RAM_ADDRA;
    logic [7:0]    RAM_DIA;
    logic          RAM_DIPA;
    logic          RAM_ENA;
    logic          RAM_WEA;
    logic [10:0]   RAM_ADDRB;
    logic          RAM_ENB;
    logic [7:0]    RAM_DOB;
    logic          RAM_DOPB;

    int checks = 0;
    int errors = 0;

    // RAM model: corrupt_wr flips the stored parity of the byte written now.
    logic       corrupt_wr;
    logic [8:0] mem [0:2047];

    // Reference model: RAM contents as a queue of {bad_parity, byte}, plus head.
    logic [8:0] q [$];
    logic       hv;
    logic [8:0] hd;
    logic       sticky;
    int         wcnt;
    int         rcnt;

    byte_fifo_ctrl #(.ADDR_W(AW), .PARITY_ODD(1'b0)) dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
        .WR_VALID(WR_VALID), .WR_READY(WR_READY), .WR_DATA(WR_DATA),
        .RD_VALID(RD_VALID), .RD_READY(RD_READY), .RD_DATA(RD_DATA),
        .RD_PERR(RD_PERR), .PERR_STICKY(PERR_STICKY), .COUNT(COUNT),
        .RAM_ADDRA(RAM_ADDRA), .RAM_DIA(RAM_DIA), .RAM_DIPA(RAM_DIPA),
        .RAM_ENA(RAM_ENA), .RAM_WEA(RAM_WEA), .RAM_ADDRB(RAM_ADDRB),
        .RAM_ENB(RAM_ENB), .RAM_DOB(RAM_DOB), .RAM_DOPB(RAM_DOPB)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (RAM_ENA && RAM_WEA) mem[RAM_ADDRA] <= {RAM_DIPA ^ corrupt_wr, RAM_DIA};
        if (RAM_ENB) {RAM_DOPB, RAM_DOB} <= mem[RAM_ADDRB];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        hv     = 1'b0;
        sticky = 1'b0;
        wcnt   = 0;
        rcnt   = 0;
    endtask

    // Called 1 time unit after a rising edge; checks mid-cycle, then
    // advances the model and returns 1 unit after the next rising edge.
    task automatic step(input logic fl, input logic wv, input logic rr,
                        input logic [7:0] d, input logic bad);
        logic exp_wr, acc, fet;
        FLUSH      = fl;
        WR_VALID   = wv;
        RD_READY   = rr;
        WR_DATA    = d;
        corrupt_wr = bad;
        #4;
        exp_wr = !fl && (q.size() < DEP);
        acc    = wv && exp_wr;
        fet    = !fl && (q.size() != 0) && (!hv || rr);
        chk("wr_ready",    WR_READY,    exp_wr);
        chk("rd_valid",    RD_VALID,    hv);
        chk("count",       COUNT,       q.size() + hv);
        chk("rd_perr",     RD_PERR,     hv && hd[8]);
        chk("perr_sticky", PERR_STICKY, sticky);
        chk("ram_ena",     RAM_ENA,     acc);
        chk("ram_wea",     RAM_WEA,     acc);
        chk("ram_enb",     RAM_ENB,     fet);
        if (hv) chk("rd_data", RD_DATA, hd[7:0]);
        if (acc) begin
            chk("ram_addra", RAM_ADDRA, wcnt % DEP);
            chk("ram_dia",   RAM_DIA,   d);
            chk("ram_dipa",  RAM_DIPA,  ^d);
        end
        if (fet) chk("ram_addrb", RAM_ADDRB, rcnt % DEP);
        if (fl) begin
            model_reset();
        end else begin
            if (hv && hd[8]) sticky = 1'b1;
            if (fet) begin
                hd = q.pop_front();
                hv = 1'b1;
                rcnt++;
            end else if (rr) begin
                hv = 1'b0;
            end
            if (acc) begin
                q.push_back({bad, d});
                wcnt++;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_ready"}, WR_READY, 0);
        chk({tag, "_rd_valid"}, RD_VALID, 0);
        chk({tag, "_rd_perr"},  RD_PERR, 0);
        chk({tag, "_sticky"},   PERR_STICKY, 0);
        chk({tag, "_count"},    COUNT, 0);
        chk({tag, "_ena"},      RAM_ENA, 0);
        chk({tag, "_wea"},      RAM_WEA, 0);
        chk({tag, "_enb"},      RAM_ENB, 0);
        chk({tag, "_addra"},    RAM_ADDRA, 0);
        chk({tag, "_addrb"},    RAM_ADDRB, 0);
        chk({tag, "_dia"},      RAM_DIA, 0);
        chk({tag, "_dipa"},     RAM_DIPA, 0);
    endtask

    initial begin
        // Reset with a write offered: nothing may leak to the RAM port.
        RST        = 1'b1;
        FLUSH      = 1'b0;
        WR_VALID   = 1'b1;
        RD_READY   = 1'b1;
        WR_DATA    = 8'h5B;
        corrupt_wr = 1'b0;
        model_reset();
        #3;
        chk_all_zero("reset");
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Single byte, consumer stalled: head appears two cycles later and holds.
        step(1'b0, 1'b1, 1'b0, 8'hA5, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("t1_data",  RD_DATA, 8'hA5);
        chk("t1_count", COUNT, 1);

        // Fill to DEPTH+1, one refused write, then drain.
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i <= 16; i++) step(1'b0, 1'b1, 1'b0, 8'(i), 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h77, 1'b0);
        chk("t2_full_count", COUNT, 17);
        chk("t2_full_ready", WR_READY, 0);
        repeat (20) step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        chk("t2_empty_count", COUNT, 0);
        chk("t2_empty_ready", WR_READY, 1);

        // Streaming at full rate across many pointer wraps.
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 1000; i++) step(1'b0, 1'b1, 1'b1, 8'(i), 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);

        // Third stored entry carries a bad parity bit.
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h10 + i), (i == 2));
        repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        repeat (8) step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        chk("t4_sticky_held", PERR_STICKY, 1);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("t4_sticky_flushed", PERR_STICKY, 0);

        // FLUSH with 5 held and a write offered in the same cycle.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'(8'hC0 + i), (i == 0));
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("t5_count5", COUNT, 5);
        step(1'b1, 1'b1, 1'b0, 8'hEE, 1'b0);
        chk("t5_count0", COUNT, 0);
        chk("t5_valid0", RD_VALID, 0);
        chk("t5_sticky0", PERR_STICKY, 0);
        step(1'b0, 1'b1, 1'b0, 8'h3C, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("t5_data", RD_DATA, 8'h3C);

        // Random traffic: fill-biased, drain-biased, then balanced with flushes.
        for (int i = 0; i < 800; i++)
            step(1'b0, $urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0,
                 8'($urandom), $urandom_range(0, 40) == 0);
        for (int i = 0; i < 800; i++)
            step(1'b0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) != 0,
                 8'($urandom), $urandom_range(0, 40) == 0);
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 40) == 0);

        // Asynchronous reset between edges while traffic is live.
        repeat (8) step(1'b0, 1'b1, 1'b0, 8'($urandom), 1'b0);
        WR_VALID = 1'b1;
        RD_READY = 1'b1;
        WR_DATA  = 8'h5B;
        #2;
        RST = 1'b1;
        #1;
        chk_all_zero("async_rst");
        @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();
        for (int i = 0; i < 300; i++)
            step(1'b0, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
                 8'($urandom), $urandom_range(0, 30) == 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
